// File: rtl/gat_load_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : gat_load_bridge
//  Description : Host-to-core bridge for the GAT accelerator. Word-aligns and
//                narrows the host load channels, counts loads, and sequences
//                the core through load/run/done. Pipelined feature readback.
//  Revision    : 1.0 - initial release
// ============================================================================
module gat_load_bridge #(
  parameter int TOP_WIDTH     = 32,
  parameter int NUM_CH        = 3,
  parameter int CH_DATA_WIDTH = 21,
  parameter int CH_ADDR_W     = 18,
  parameter int FEAT_ADDR_W   = 16,
  parameter int FEAT_WIDTH    = 32,
  parameter int RD_LATENCY    = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              gat_layer,
  input  logic [NUM_CH*(CH_ADDR_W+1)-1:0]   exp_cnt,
  input  logic [NUM_CH*TOP_WIDTH-1:0]       host_din,
  input  logic [NUM_CH-1:0]                 host_ena,
  input  logic [NUM_CH-1:0]                 host_wea,
  input  logic [NUM_CH*(CH_ADDR_W+2)-1:0]   host_addra,
  output logic [NUM_CH*CH_DATA_WIDTH-1:0]   bram_din,
  output logic [NUM_CH-1:0]                 bram_ena,
  output logic [NUM_CH-1:0]                 bram_wea,
  output logic [NUM_CH*CH_ADDR_W-1:0]       bram_addra,
  output logic [NUM_CH-1:0]                 load_done,
  output logic                              core_start,
  output logic                              core_layer,
  input  logic                              core_done,
  output logic                              gat_ready,
  input  logic                              feat_rd_en,
  input  logic [FEAT_ADDR_W+1:0]            feat_rd_addr,
  output logic [FEAT_ADDR_W-1:0]            feat_bram_addrb,
  input  logic [FEAT_WIDTH-1:0]             feat_bram_dout,
  output logic [FEAT_WIDTH-1:0]             feat_dout,
  output logic                              feat_dout_valid,
  output logic [TOP_WIDTH-1:0]              status
);

  localparam int                 c_cnt_w   = CH_ADDR_W + 1;
  localparam int                 c_ha_w    = CH_ADDR_W + 2;
  localparam logic [CH_ADDR_W:0] c_cnt_one = {{CH_ADDR_W{1'b0}}, 1'b1};
  localparam logic [15:0]        c_run_max = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt [NUM_CH];
  logic [c_cnt_w-1:0]  r_exp [NUM_CH];
  logic [NUM_CH-1:0]   w_req;
  logic [NUM_CH-1:0]   w_aligned;
  logic [NUM_CH-1:0]   w_accept;
  logic [NUM_CH-1:0]   w_count;
  logic [NUM_CH-1:0]   w_hit;
  logic                w_start_acc;
  logic                w_in_run;
  logic                r_drop_err;
  logic                r_align_err;
  logic [15:0]         r_run_cnt;
  logic [RD_LATENCY-1:0] r_rd_pipe;
  logic                w_unused;

  // Host data above CH_DATA_WIDTH and the byte offset of readback are ignored
  assign w_unused    = ^{host_din, feat_rd_addr[1:0]};

  assign w_in_run    = (r_state == S_RUN);
  assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign gat_ready   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign status      = {r_state, r_drop_err, r_align_err,
                        {(TOP_WIDTH-20){1'b0}}, r_run_cnt};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start)      w_state_nxt = S_LOAD;
      S_LOAD:         if (&load_done) w_state_nxt = S_RUN;
      S_RUN:          if (core_done)  w_state_nxt = S_DONE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_req     = '0;
    w_aligned = '0;
    w_accept  = '0;
    w_count   = '0;
    w_hit     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_req[c]     = host_ena[c] & host_wea[c];
      w_aligned[c] = (host_addra[c*c_ha_w +: 2] == 2'b00);
      w_accept[c]  = w_req[c] & w_aligned[c] & ~w_in_run;
      // Only LOAD-state writes count, and counting stops once the channel is done
      w_count[c]   = w_accept[c] & (r_state == S_LOAD) & ~load_done[c];
      w_hit[c]     = ((r_cnt[c] + c_cnt_one) == r_exp[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      core_start  <= 1'b0;
      core_layer  <= 1'b0;
      r_drop_err  <= 1'b0;
      r_align_err <= 1'b0;
      r_run_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      core_start <= (r_state == S_LOAD) && (&load_done);
      if (w_start_acc) begin
        core_layer  <= gat_layer;
        r_drop_err  <= 1'b0;
        r_align_err <= 1'b0;
        r_run_cnt   <= '0;
      end else begin
        if (|(w_req & {NUM_CH{w_in_run}})) r_drop_err  <= 1'b1;
        if (|(w_req & ~w_aligned))         r_align_err <= 1'b1;
        if (w_in_run && (r_run_cnt != c_run_max))
          r_run_cnt <= r_run_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_din   <= '0;
      bram_ena   <= '0;
      bram_wea   <= '0;
      bram_addra <= '0;
      load_done  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= '0;
        r_exp[c] <= '0;
      end
    end else begin
      bram_ena <= w_accept;
      bram_wea <= w_accept;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_accept[c]) begin
          bram_din[c*CH_DATA_WIDTH +: CH_DATA_WIDTH] <= host_din[c*TOP_WIDTH +: CH_DATA_WIDTH];
          bram_addra[c*CH_ADDR_W +: CH_ADDR_W]       <= host_addra[c*c_ha_w+2 +: CH_ADDR_W];
        end
        if (w_start_acc) begin
          r_cnt[c]     <= '0;
          r_exp[c]     <= exp_cnt[c*c_cnt_w +: c_cnt_w];
          // A zero-length channel is complete as soon as LOAD begins
          load_done[c] <= (exp_cnt[c*c_cnt_w +: c_cnt_w] == '0);
        end else if (w_count[c]) begin
          r_cnt[c] <= r_cnt[c] + c_cnt_one;
          if (w_hit[c]) load_done[c] <= 1'b1;
        end
      end
    end
  end

  // Readback request delay line; independent of the load/run sequencing
  if (RD_LATENCY == 1) begin : g_rd_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rd_pipe <= '0;
      else     r_rd_pipe <= feat_rd_en;
    end
  end else begin : g_rd_latn
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rd_pipe <= '0;
      else     r_rd_pipe <= {r_rd_pipe[RD_LATENCY-2:0], feat_rd_en};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_bram_addrb <= '0;
      feat_dout       <= '0;
      feat_dout_valid <= 1'b0;
    end else begin
      if (feat_rd_en) feat_bram_addrb <= feat_rd_addr[FEAT_ADDR_W+1:2];
      feat_dout_valid <= r_rd_pipe[RD_LATENCY-1];
      if (r_rd_pipe[RD_LATENCY-1]) feat_dout <= feat_bram_dout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gat_load_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gat_load_bridge
//  Description : Directed self-checking bench for gat_load_bridge with a
//                scoreboard for forwarded writes and feature readback.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gat_load_bridge;

  localparam int TOP_WIDTH     = 32;
  localparam int NUM_CH        = 3;
  localparam int CH_DATA_WIDTH = 21;
  localparam int CH_ADDR_W     = 18;
  localparam int FEAT_ADDR_W   = 16;
  localparam int FEAT_WIDTH    = 32;
  localparam int RD_LATENCY    = 2;
  localparam int c_ha_w        = CH_ADDR_W + 2;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic gat_layer;
  logic [NUM_CH*(CH_ADDR_W+1)-1:0] exp_cnt;
  logic [NUM_CH*TOP_WIDTH-1:0]     host_din;
  logic [NUM_CH-1:0]               host_ena;
  logic [NUM_CH-1:0]               host_wea;
  logic [NUM_CH*c_ha_w-1:0]        host_addra;
  logic [NUM_CH*CH_DATA_WIDTH-1:0] bram_din;
  logic [NUM_CH-1:0]               bram_ena;
  logic [NUM_CH-1:0]               bram_wea;
  logic [NUM_CH*CH_ADDR_W-1:0]     bram_addra;
  logic [NUM_CH-1:0]               load_done;
  logic                            core_start;
  logic                            core_layer;
  logic                            core_done;
  logic                            gat_ready;
  logic                            feat_rd_en;
  logic [FEAT_ADDR_W+1:0]          feat_rd_addr;
  logic [FEAT_ADDR_W-1:0]          feat_bram_addrb;
  logic [FEAT_WIDTH-1:0]           feat_bram_dout;
  logic [FEAT_WIDTH-1:0]           feat_dout;
  logic                            feat_dout_valid;
  logic [TOP_WIDTH-1:0]            status;

  gat_load_bridge #(
    .TOP_WIDTH(TOP_WIDTH), .NUM_CH(NUM_CH), .CH_DATA_WIDTH(CH_DATA_WIDTH),
    .CH_ADDR_W(CH_ADDR_W), .FEAT_ADDR_W(FEAT_ADDR_W), .FEAT_WIDTH(FEAT_WIDTH),
    .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .gat_layer(gat_layer),
    .exp_cnt(exp_cnt), .host_din(host_din), .host_ena(host_ena),
    .host_wea(host_wea), .host_addra(host_addra), .bram_din(bram_din),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
    .load_done(load_done), .core_start(core_start), .core_layer(core_layer),
    .core_done(core_done), .gat_ready(gat_ready), .feat_rd_en(feat_rd_en),
    .feat_rd_addr(feat_rd_addr), .feat_bram_addrb(feat_bram_addrb),
    .feat_bram_dout(feat_bram_dout), .feat_dout(feat_dout),
    .feat_dout_valid(feat_dout_valid), .status(status)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core feature BRAM: registered output, so data is ready RD_LATENCY cycles after the request
  logic [FEAT_WIDTH-1:0] fmem [16];
  logic [FEAT_WIDTH-1:0] r_fdout = '0;
  always @(posedge clk) r_fdout <= fmem[feat_bram_addrb[3:0]];
  assign feat_bram_dout = r_fdout;

  typedef struct packed {
    logic [1:0]               ch;
    logic [CH_ADDR_W-1:0]     addr;
    logic [CH_DATA_WIDTH-1:0] din;
  } wr_t;

  typedef struct packed {
    logic [FEAT_WIDTH-1:0] data;
    logic [31:0]           due;
  } rd_t;

  wr_t wq[$];
  rd_t rq[$];
  wr_t we;
  rd_t re;
  int  checks = 0;
  int  errors = 0;
  int  n_run;
  logic [NUM_CH-1:0] exp_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [c_ha_w-1:0] addr,
                    input logic [31:0] data, input bit fwd);
    host_ena[ch] = 1'b1;
    host_wea[ch] = 1'b1;
    host_addra[ch*c_ha_w +: c_ha_w] = addr;
    host_din[ch*TOP_WIDTH +: TOP_WIDTH] = data;
    if (fwd) wq.push_back('{2'(ch), addr[c_ha_w-1:2], data[CH_DATA_WIDTH-1:0]});
  endtask

  task automatic clr_wr();
    host_ena = '0;
    host_wea = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_bram_din"},   bram_din, 0);
    check({tag, "_bram_ena"},   {bram_ena, bram_wea}, 0);
    check({tag, "_bram_addra"}, bram_addra, 0);
    check({tag, "_load_done"},  load_done, 0);
    check({tag, "_core"},       {core_start, core_layer}, 0);
    check({tag, "_feat"},       {feat_dout_valid, feat_dout, feat_bram_addrb}, 0);
    check({tag, "_status"},     status, 0);
    check({tag, "_ready"},      gat_ready, 1);
  endtask

  // Scoreboard: pop expected writes/reads as the DUT presents them
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bram_ena[c]) begin
          check("wr_pending", wq.size() != 0, 1);
          if (wq.size() != 0) begin
            we = wq.pop_front();
            check("wr_ch",   we.ch, c);
            check("wr_addr", bram_addra[c*CH_ADDR_W +: CH_ADDR_W], we.addr);
            check("wr_din",  bram_din[c*CH_DATA_WIDTH +: CH_DATA_WIDTH], we.din);
            check("wr_wea",  bram_wea[c], 1);
          end
        end
      end
      if (feat_dout_valid) begin
        check("rd_pending", rq.size() != 0, 1);
        if (rq.size() != 0) begin
          re = rq.pop_front();
          check("rd_data",  feat_dout, re.data);
          check("rd_cycle", cyc, re.due);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) fmem[i] = $urandom;
    rst = 1'b1; start = 1'b0; gat_layer = 1'b0; exp_cnt = '0;
    host_din = '0; host_ena = '0; host_wea = '0; host_addra = '0;
    core_done = 1'b0; feat_rd_en = 1'b0; feat_rd_addr = '0;
    repeat (3) tick();
    check_reset("rst0");
    rst = 1'b0;
    tick();

    // IDLE preload is forwarded, truncated, word-addressed
    wr(0, 20'h1C, 32'hABCDEF12, 1'b1);
    tick();
    clr_wr();
    check("pre_addr", bram_addra[CH_ADDR_W-1:0], 7);
    check("pre_din", bram_din[CH_DATA_WIDTH-1:0], 21'h0DEF12);
    check("pre_status", status, 0);

    // Load with exp_cnt ch0=4, ch1=2, ch2=3
    exp_cnt = {19'd3, 19'd2, 19'd4};
    gat_layer = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("ld_state", status[31:30], 1);
    check("ld_ready", gat_ready, 0);
    check("ld_layer", core_layer, 1);
    check("ld_done0", load_done, 0);
    for (int k = 0; k < 4; k++) begin
      wr(0, 20'(k*4), $urandom, 1'b1);
      if (k < 2) wr(1, 20'(16 + k*4), $urandom, 1'b1);
      if (k < 3) wr(2, 20'(64 + k*4), $urandom, 1'b1);
      tick();
      clr_wr();
      exp_done = {(k >= 2), (k >= 1), (k >= 3)};
      check("ld_flags", load_done, exp_done);
      check("ld_cs_low", core_start, 0);
    end
    tick();
    check("run_cs", core_start, 1);
    check("run_state", status[31:30], 2);
    n_run = 1;
    tick(); n_run++;
    check("run_cs_once", core_start, 0);

    // Aligned write and ignored start in RUN, then misaligned write
    start = 1'b1; exp_cnt = '0;
    wr(2, 20'h40, $urandom, 1'b0);
    tick(); n_run++;
    start = 1'b0;
    clr_wr();
    check("drop_ena", bram_ena, 0);
    check("drop_state", status[31:30], 2);
    check("drop_err", status[29:28], 2'b10);
    wr(1, 20'h1E, $urandom, 1'b0);
    tick(); n_run++;
    clr_wr();
    check("mis_ena", bram_ena, 0);
    check("mis_err", status[29:28], 2'b11);

    // core_done wins over a simultaneous start
    start = 1'b1; core_done = 1'b1;
    tick();
    start = 1'b0; core_done = 1'b0;
    check("done_state", status[31:30], 3);
    check("done_ready", gat_ready, 1);
    check("done_runcnt", status[15:0], n_run);
    check("done_err", status[29:28], 2'b11);

    // Zero-length load from DONE
    exp_cnt = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("z_state", status[31:30], 1);
    check("z_clear", {status[29:28], status[15:0]}, 0);
    check("z_cs_low", core_start, 0);
    tick();
    check("z_cs", core_start, 1);
    repeat (9) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("z_runcnt", status[15:0], 10);
    check("z_ready", gat_ready, 1);

    // Back-to-back readback
    for (int i = 0; i < 3; i++) begin
      feat_rd_en = 1'b1;
      feat_rd_addr = 18'(i*4);
      rq.push_back('{fmem[i], 32'(cyc + RD_LATENCY + 1)});
      tick();
    end
    feat_rd_en = 1'b0;
    for (int b = 0; b < 20 && rq.size() != 0; b++) tick();
    check("rd_drain", rq.size(), 0);
    check("rd_hold", feat_dout, fmem[2]);
    check("rd_vlow", feat_dout_valid, 0);
    check("rd_addrb", feat_bram_addrb, 2);

    // Reset mid-LOAD with a read in flight
    exp_cnt = {19'd4, 19'd4, 19'd4};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NUM_CH; c++) wr(c, 20'(c*256 + k*4), $urandom, 1'b1);
      tick();
      clr_wr();
    end
    feat_rd_en = 1'b1; feat_rd_addr = 18'd12;
    tick();
    feat_rd_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("rst1");
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("rst_novalid", feat_dout_valid, 0);

    exp_cnt = {19'd1, 19'd1, 19'd1};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < NUM_CH; c++) wr(c, 20'(c*8), $urandom, 1'b1);
    tick();
    clr_wr();
    check("one_done", load_done, 3'b111);
    tick();
    check("one_cs", core_start, 1);
    tick();
    check("wq_empty", wq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
